ym_stereo_mix: RTL and testbench



---
 rtl/ym_stereo_mix.sv | 158 +++++++++++++++
 tb/tb_ym_stereo_mix.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ym_stereo_mix.sv
// rtl/ym_stereo_mix.sv - TurboSound stereo mixer with optional delta-sigma DAC outputs (YM_MIX_DAC_EN)
module ym_stereo_mix (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        CE,
  input  logic [7:0]  CH_A0,
  input  logic [7:0]  CH_B0,
  input  logic [7:0]  CH_C0,
  input  logic [7:0]  CH_A1,
  input  logic [7:0]  CH_B1,
  input  logic [7:0]  CH_C1,
  input  logic [1:0]  STEREO,
  input  logic [1:0]  CHIP_EN,
  output logic [11:0] AUDIO_L,
  output logic [11:0] AUDIO_R,
  output logic        VALID,
  output logic        DAC_L,
  output logic        DAC_R
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t      state, state_nxt;
  logic        capture;
  logic        pending;
  logic [2:0]  idx;
  logic [10:0] acc_l, acc_r;
  logic [10:0] add_l, add_r;
  logic [7:0]  snap_a0, snap_b0, snap_c0, snap_a1, snap_b1, snap_c1;
  logic [1:0]  stereo_q;
  logic [7:0]  v;
  logic [1:0]  kind;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: if (CE || pending) begin
        capture   = 1'b1;
        state_nxt = ACC;
      end
      ACC:  if (idx == 3'd5) state_nxt = OUT;
      OUT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Channel under the accumulator this cycle and its A/B/C position
  always_comb begin
    v    = 8'd0;
    kind = 2'd0;
    case (idx)
      3'd0: begin v = snap_a0; kind = 2'd0; end
      3'd1: begin v = snap_b0; kind = 2'd1; end
      3'd2: begin v = snap_c0; kind = 2'd2; end
      3'd3: begin v = snap_a1; kind = 2'd0; end
      3'd4: begin v = snap_b1; kind = 2'd1; end
      3'd5: begin v = snap_c1; kind = 2'd2; end
      default: begin v = 8'd0; kind = 2'd0; end
    endcase
  end

  always_comb begin
    add_l = 11'd0;
    add_r = 11'd0;
    if (stereo_q[1]) begin
      add_l = {3'b000, v};
      add_r = {3'b000, v};
    end else begin
      case (kind)
        2'd0: add_l = {2'b00, v, 1'b0};
        2'd1: if (stereo_q[0]) add_r = {2'b00, v, 1'b0};
              else begin add_l = {3'b000, v}; add_r = {3'b000, v}; end
        2'd2: if (stereo_q[0]) begin add_l = {3'b000, v}; add_r = {3'b000, v}; end
              else add_r = {2'b00, v, 1'b0};
        default: begin add_l = 11'd0; add_r = 11'd0; end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pending  <= 1'b0;
      idx      <= 3'd0;
      acc_l    <= 11'd0;
      acc_r    <= 11'd0;
      snap_a0  <= 8'd0;
      snap_b0  <= 8'd0;
      snap_c0  <= 8'd0;
      snap_a1  <= 8'd0;
      snap_b1  <= 8'd0;
      snap_c1  <= 8'd0;
      stereo_q <= 2'd0;
      AUDIO_L  <= 12'd0;
      AUDIO_R  <= 12'd0;
      VALID    <= 1'b0;
    end else begin
      VALID <= 1'b0;
      if (capture) begin
        snap_a0  <= CHIP_EN[0] ? CH_A0 : 8'd0;
        snap_b0  <= CHIP_EN[0] ? CH_B0 : 8'd0;
        snap_c0  <= CHIP_EN[0] ? CH_C0 : 8'd0;
        snap_a1  <= CHIP_EN[1] ? CH_A1 : 8'd0;
        snap_b1  <= CHIP_EN[1] ? CH_B1 : 8'd0;
        snap_c1  <= CHIP_EN[1] ? CH_C1 : 8'd0;
        stereo_q <= STEREO;
        acc_l    <= 11'd0;
        acc_r    <= 11'd0;
        idx      <= 3'd0;
        pending  <= 1'b0;
      end else if (CE && state != IDLE) begin
        pending <= 1'b1;
      end
      if (state == ACC) begin
        acc_l <= acc_l + add_l;
        acc_r <= acc_r + add_r;
        idx   <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end
      if (state == OUT) begin
        AUDIO_L <= {1'b0, acc_l};
        AUDIO_R <= {1'b0, acc_r};
        VALID   <= 1'b1;
      end
    end
  end

`ifdef YM_MIX_DAC_EN
  logic [11:0] ds_l, ds_r;
  logic [12:0] sum_l, sum_r;

  // Carry out of a 12-bit phase accumulator gives a ones density of AUDIO/4096
  assign sum_l = {1'b0, ds_l} + {1'b0, AUDIO_L};
  assign sum_r = {1'b0, ds_r} + {1'b0, AUDIO_R};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ds_l  <= 12'd0;
      ds_r  <= 12'd0;
      DAC_L <= 1'b0;
      DAC_R <= 1'b0;
    end else begin
      ds_l  <= sum_l[11:0];
      ds_r  <= sum_r[11:0];
      DAC_L <= sum_l[12];
      DAC_R <= sum_r[12];
    end
  end
`else
  assign DAC_L = 1'b0;
  assign DAC_R = 1'b0;
`endif

endmodule

// File: tb/tb_ym_stereo_mix.sv
// tb/tb_ym_stereo_mix.sv - table-driven and sequence checks for ym_stereo_mix
module tb_ym_stereo_mix;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        CE;
  logic [7:0]  CH_A0, CH_B0, CH_C0, CH_A1, CH_B1, CH_C1;
  logic [1:0]  STEREO, CHIP_EN;
  logic [11:0] AUDIO_L, AUDIO_R;
  logic        VALID, DAC_L, DAC_R;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [1:0]  stereo;
    logic [1:0]  chip_en;
    logic [7:0]  a0, b0, c0, a1, b1, c1;
    logic [11:0] l, r;
  } vec_t;

  vec_t vecs [0:8];

  ym_stereo_mix dut (
    .CLK(CLK), .RESET_N(RESET_N), .CE(CE),
    .CH_A0(CH_A0), .CH_B0(CH_B0), .CH_C0(CH_C0),
    .CH_A1(CH_A1), .CH_B1(CH_B1), .CH_C1(CH_C1),
    .STEREO(STEREO), .CHIP_EN(CHIP_EN),
    .AUDIO_L(AUDIO_L), .AUDIO_R(AUDIO_R), .VALID(VALID),
    .DAC_L(DAC_L), .DAC_R(DAC_R)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic set_in(input vec_t v);
    STEREO  = v.stereo;
    CHIP_EN = v.chip_en;
    CH_A0 = v.a0; CH_B0 = v.b0; CH_C0 = v.c0;
    CH_A1 = v.a1; CH_B1 = v.b1; CH_C1 = v.c1;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int n;
    set_in(v);
    CE = 1'b1;
    tick();
    CE = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!VALID && n < 30);
    check({name, "_latency"}, n, 7);
    check({name, "_L"}, int'(AUDIO_L), int'(v.l));
    check({name, "_R"}, int'(AUDIO_R), int'(v.r));
    tick();
    check({name, "_valid_low"}, int'(VALID), 0);
  endtask

  initial begin
    int vc [0:3];
    int vl [0:3];
    int vr [0:3];
    int np;
    int pulses;
    int ones_l, ones_r;
    int exp_ones;

    vecs[0] = '{2'b00, 2'b11, 8'd255, 8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   12'd510,  12'd0};
    vecs[1] = '{2'b01, 2'b11, 8'd0,   8'd255, 8'd0,   8'd0,   8'd255, 8'd0,   12'd0,    12'd1020};
    vecs[2] = '{2'b01, 2'b11, 8'd0,   8'd0,   8'd100, 8'd0,   8'd0,   8'd0,   12'd100,  12'd100};
    vecs[3] = '{2'b10, 2'b11, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 12'd1530, 12'd1530};
    vecs[4] = '{2'b11, 2'b01, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 12'd765,  12'd765};
    vecs[5] = '{2'b00, 2'b11, 8'd10,  8'd20,  8'd30,  8'd40,  8'd50,  8'd60,  12'd170,  12'd250};
    vecs[6] = '{2'b01, 2'b11, 8'd10,  8'd20,  8'd30,  8'd40,  8'd50,  8'd60,  12'd190,  12'd230};
    vecs[7] = '{2'b00, 2'b10, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 12'd765,  12'd765};
    vecs[8] = '{2'b00, 2'b00, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 12'd0,    12'd0};

    RESET_N = 1'b0;
    CE = 1'b0;
    set_in(vecs[8]);
    tick();
    tick();
    check("reset_audio_l", int'(AUDIO_L), 0);
    check("reset_audio_r", int'(AUDIO_R), 0);
    check("reset_valid", int'(VALID), 0);
    check("reset_dac_l", int'(DAC_L), 0);
    RESET_N = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // CE at e0, then at e3 and e5 while busy: one deferred run sampled at e8
    np = 0;
    set_in(vecs[0]);
    CE = 1'b1;
    tick();
    CE = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (cyc == 3) begin CE = 1'b1; set_in(vecs[2]); STEREO = 2'b00; CH_C0 = 8'd0; CH_B0 = 8'd100; end
      if (cyc == 4) begin CE = 1'b0; set_in(vecs[1]); CH_B1 = 8'd0; CH_B0 = 8'd100; end
      if (cyc == 5) CE = 1'b1;
      if (cyc == 6) CE = 1'b0;
      tick();
      if (VALID && np < 4) begin
        vc[np] = cyc; vl[np] = int'(AUDIO_L); vr[np] = int'(AUDIO_R); np++;
      end
    end
    check("defer_pulses", np, 2);
    check("defer_first_cyc", vc[0], 7);
    check("defer_first_L", vl[0], 510);
    check("defer_first_R", vr[0], 0);
    check("defer_second_cyc", vc[1], 15);
    check("defer_second_L", vl[1], 0);
    check("defer_second_R", vr[1], 200);

    // CE coinciding with VALID at e7 starts the next run at e8
    np = 0;
    set_in(vecs[5]);
    CE = 1'b1;
    tick();
    CE = 1'b0;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      if (cyc == 7) begin CE = 1'b1; set_in(vecs[6]); end
      if (cyc == 8) CE = 1'b0;
      tick();
      if (VALID && np < 4) begin
        vc[np] = cyc; vl[np] = int'(AUDIO_L); vr[np] = int'(AUDIO_R); np++;
      end
    end
    check("ce_at_valid_pulses", np, 2);
    check("ce_at_valid_first_cyc", vc[0], 7);
    check("ce_at_valid_first_L", vl[0], 170);
    check("ce_at_valid_second_cyc", vc[1], 15);
    check("ce_at_valid_second_L", vl[1], 190);
    check("ce_at_valid_second_R", vr[1], 230);

    // Reset asserted mid-run at e4
    set_in(vecs[3]);
    CE = 1'b1;
    tick();
    CE = 1'b0;
    repeat (4) tick();
    RESET_N = 1'b0;
    #1;
    check("midreset_audio_l", int'(AUDIO_L), 0);
    check("midreset_audio_r", int'(AUDIO_R), 0);
    check("midreset_valid", int'(VALID), 0);
    check("midreset_dac_l", int'(DAC_L), 0);
    check("midreset_dac_r", int'(DAC_R), 0);
    tick();
    tick();
    RESET_N = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (VALID) pulses++;
    end
    check("midreset_no_valid", pulses, 0);
    run_vec(vecs[5], "post_reset");

    // Delta-sigma density with L=R=1530 held
    run_vec(vecs[3], "dac_setup");
    repeat (3) tick();
    ones_l = 0;
    ones_r = 0;
    for (int k = 0; k < 4096; k++) begin
      tick();
      ones_l += int'(DAC_L);
      ones_r += int'(DAC_R);
    end
`ifdef YM_MIX_DAC_EN
    exp_ones = 1530;
`else
    exp_ones = 0;
`endif
    check("dac_l_ones", ones_l, exp_ones);
    check("dac_r_ones", ones_r, exp_ones);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
